alu_issue: RTL
==============

Name: alu_issue

Overview:
- Decode/operand-issue stage that feeds the clocked ALU.
- Accepts one 32-bit RV64I instruction per handshake and reads rs1/rs2 from an internal 32x64 register file.
- Issues op1, op2, imm, funct3, funct7 and rd to the ALU through a registered valid/ready output.
- Owns the architectural register file; the ALU result returns through the writeback port.

Parameters:
- XLEN, 64, operand and register width; only 64 is supported.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- inst_valid  input  1  instruction presented.
- inst_ready  output  1  stage can accept an instruction this cycle.
- inst  input  32  RV64 instruction word.
- pc  input  XLEN  address of inst; used by AUIPC.
- wb_en  input  1  register-file write strobe.
- wb_rd  input  5  write index.
- wb_data  input  XLEN  write data.
- out_valid  output  1  issue register holds a valid op.
- out_ready  input  1  ALU consumes the op.
- imm  output  1  op2 is an immediate; drives ALU imm.
- op1  output  XLEN  first operand.
- op2  output  XLEN  second operand.
- funct3  output  3  ALU function select.
- funct7  output  7  ALU function modifier.
- rd  output  5  destination register, carried to writeback.
- illegal  output  1  opcode not supported; op is a no-op.

Behaviour:
- Reset, sampled on a CLK edge with RST=1:
  - out_valid, imm, illegal = 0.
  - op1, op2 = 0; funct3, funct7, rd = 0.
  - All registers x1..x31 = 0.
  - An op held in the issue register is discarded.
  - A wb_en in the same cycle is ignored.
- Handshake:
  - inst_ready = !out_valid || out_ready, combinational.
  - Accept when inst_valid && inst_ready. The decoded op appears on the outputs the next cycle with out_valid=1 (latency 1).
  - While out_valid && !out_ready, all outputs hold stable.
  - When out_ready=1 with no new accept, out_valid falls to 0 next cycle.
  - Back-to-back accepts sustain 1 op/cycle.
- Register file:
  - Write on wb_en && wb_rd!=0. Writes to x0 are dropped; x0 always reads 0.
  - Read bypass: if wb_en && wb_rd==rs && rs!=0 in the accept cycle, the operand takes wb_data, not the stale entry.
- Decode, opcode = inst[6:0]:
  - 0110011 (OP): imm=0; op1=R[rs1]; op2=R[rs2]; funct3=inst[14:12]; funct7=inst[31:25].
  - 0010011 (OP-IMM): imm=1; op1=R[rs1]; funct3=inst[14:12].
    - funct3 in {001,101}: op2 = zero-extended inst[25:20] (6-bit shamt); funct7 = {inst[31:26],1'b0}.
    - Otherwise: op2 = sign-extended inst[31:20]; funct7 = 0.
  - 0110111 (LUI): imm=1; op1=0; op2 = sign-extended {inst[31:12],12'b0}; funct3=000; funct7=0.
  - 0010111 (AUIPC): imm=1; op1=pc; op2 as LUI; funct3=000; funct7=0.
  - In all of the above, rd = inst[11:7].
  - Any other opcode: illegal=1; op1=op2=0; funct3=000; funct7=0; imm=1; rd=0. This issues as a harmless add of 0 to x0, and is still handshaked normally.
- Arithmetic: all sign extension is to XLEN. No arithmetic is performed here except operand selection.
- Simultaneous events:
  - wb_en together with an accept reading the same register: bypass applies.
  - wb_en together with RST: reset wins.

Optional Feature:
- Macro ALU_ISSUE_RV64W_EN.
- Defined:
  - Adds output port word (1 bit; reset 0).
  - Opcode 0111011 (OP-32) decodes like OP with word=1.
  - Opcode 0011011 (OP-IMM-32) decodes like OP-IMM with word=1, except the shamt is inst[24:20] zero-extended and funct7=inst[31:25].
  - All other opcodes drive word=0.
- Not defined: no word port; 0111011 and 0011011 are illegal.

Test Plan:
- RST=1 for 2 cycles, then release -> out_valid=0, inst_ready=1, all outputs 0; issue ADD x3,x1,x2 (0x002081B3) -> op1=0, op2=0.
- Write x1=5, x2=7 via wb; accept 0x002081B3 -> next cycle out_valid=1, imm=0, op1=5, op2=7, funct3=000, funct7=0, rd=3.
- ADDI x4,x1,-1 (0xFFF08213) with wb_en, wb_rd=1, wb_data=0x10 in the same cycle -> op1=0x10 (bypass), op2=0xFFFFFFFFFFFFFFFF, imm=1.
- Hold out_ready=0 for 3 cycles after issuing SRAI x5,x1,3 (0x4030D293) -> inst_ready=0; outputs stable with op2=3, funct7=0100000; out_ready=1 -> a new op is accepted the same cycle.
- AUIPC x6,0x80000 at pc=0x1000 (0x80000317) -> op1=0x1000, op2=0xFFFFFFFF80000000. Illegal word 0x0000007F -> illegal=1, rd=0.
- wb write to x0 with 0xDEAD, then read x0 -> operand 0. RST asserted while out_valid=1 and out_ready=0 -> out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_issue.sv
// Decode/operand-issue stage for the clocked ALU. It owns the 32x64 register file and issues through a registered valid/ready slot.
// The optional ALU_ISSUE_RV64W_EN macro adds the OP-32/OP-IMM-32 decode and a 'word' output.
module alu_issue #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            imm,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
`ifdef ALU_ISSUE_RV64W_EN
    output logic            word,
`endif
    output logic            illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`ifdef ALU_ISSUE_RV64W_EN
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
`endif

    logic [XLEN-1:0] regs [NREG];

    logic [6:0]      opcode;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [2:0]      f3_field;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt6;
    logic            accept;

    logic            imm_d;
    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] op2_d;
    logic [2:0]      funct3_d;
    logic [6:0]      funct7_d;
    logic [4:0]      rd_d;
    logic            illegal_d;
`ifdef ALU_ISSUE_RV64W_EN
    logic            word_d;
    logic [XLEN-1:0] shamt5;
`endif

    assign opcode   = inst[6:0];
    assign rs1_idx  = inst[19:15];
    assign rs2_idx  = inst[24:20];
    assign f3_field = inst[14:12];
    assign imm_i    = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_u    = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign shamt6   = {{(XLEN-6){1'b0}}, inst[25:20]};
`ifdef ALU_ISSUE_RV64W_EN
    assign shamt5   = {{(XLEN-5){1'b0}}, inst[24:20]};
`endif

    assign inst_ready = !out_valid || out_ready;
    assign accept     = inst_valid && inst_ready;

    // Register file; x0 is never written, so its entry stays at its reset value of zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Same-cycle writeback forwards into the operand read so the issue never sees a stale entry.
    always_comb begin
        rs1_val = regs[rs1_idx];
        if (rs1_idx == 5'd0) begin
            rs1_val = '0;
        end else if (wb_en && wb_rd == rs1_idx) begin
            rs1_val = wb_data;
        end
    end

    always_comb begin
        rs2_val = regs[rs2_idx];
        if (rs2_idx == 5'd0) begin
            rs2_val = '0;
        end else if (wb_en && wb_rd == rs2_idx) begin
            rs2_val = wb_data;
        end
    end

    // Unsupported opcodes fall through as an add of zero into x0 with illegal raised.
    always_comb begin
        imm_d     = 1'b1;
        op1_d     = '0;
        op2_d     = '0;
        funct3_d  = 3'b000;
        funct7_d  = 7'b0;
        rd_d      = 5'd0;
        illegal_d = 1'b1;
`ifdef ALU_ISSUE_RV64W_EN
        word_d    = 1'b0;
`endif
        case (opcode)
            OPC_OP: begin
                imm_d     = 1'b0;
                op1_d     = rs1_val;
                op2_d     = rs2_val;
                funct3_d  = f3_field;
                funct7_d  = inst[31:25];
                rd_d      = inst[11:7];
                illegal_d = 1'b0;
            end
            OPC_OP_IMM: begin
                op1_d     = rs1_val;
                funct3_d  = f3_field;
                rd_d      = inst[11:7];
                illegal_d = 1'b0;
                if (f3_field == 3'b001 || f3_field == 3'b101) begin
                    op2_d    = shamt6;
                    funct7_d = {inst[31:26], 1'b0};
                end else begin
                    op2_d    = imm_i;
                end
            end
            OPC_LUI: begin
                op2_d     = imm_u;
                rd_d      = inst[11:7];
                illegal_d = 1'b0;
            end
            OPC_AUIPC: begin
                op1_d     = pc;
                op2_d     = imm_u;
                rd_d      = inst[11:7];
                illegal_d = 1'b0;
            end
`ifdef ALU_ISSUE_RV64W_EN
            OPC_OP_32: begin
                imm_d     = 1'b0;
                op1_d     = rs1_val;
                op2_d     = rs2_val;
                funct3_d  = f3_field;
                funct7_d  = inst[31:25];
                rd_d      = inst[11:7];
                illegal_d = 1'b0;
                word_d    = 1'b1;
            end
            OPC_OP_IMM_32: begin
                op1_d     = rs1_val;
                funct3_d  = f3_field;
                rd_d      = inst[11:7];
                illegal_d = 1'b0;
                word_d    = 1'b1;
                if (f3_field == 3'b001 || f3_field == 3'b101) begin
                    op2_d    = shamt5;
                    funct7_d = inst[31:25];
                end else begin
                    op2_d    = imm_i;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Issue slot: loads on accept, holds while stalled, and drops valid once consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            imm       <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            funct3    <= 3'b000;
            funct7    <= 7'b0;
            rd        <= 5'd0;
            illegal   <= 1'b0;
`ifdef ALU_ISSUE_RV64W_EN
            word      <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            imm       <= imm_d;
            op1       <= op1_d;
            op2       <= op2_d;
            funct3    <= funct3_d;
            funct7    <= funct7_d;
            rd        <= rd_d;
            illegal   <= illegal_d;
`ifdef ALU_ISSUE_RV64W_EN
            word      <= word_d;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
